// File: rtl/vr_link_pkg.sv
// vr_link_pkg: shared types and constants for the vr_link valid/ready transfer link.
//   WORD_W      - link data width
//   word_t      - one link word
//   src_state_e - source stage state (IDLE only while in reset, SEND afterwards)
package vr_link_pkg;

  localparam int unsigned WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic {
    IDLE,
    SEND
  } src_state_e;

endpackage

// File: rtl/vr_sink.sv
// vr_sink: sink stage of vr_link. Drives ready from a rotating backpressure mask,
// captures each accepted word and counts completed transfers.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   data       - link data from the source
//   valid      - link valid from the source
//   ready      - registered sink ready (bit 0 of the mask as of the previous edge)
//   data_out   - last accepted word
//   xfer_count - completed transfers, wraps at 2^16
module vr_sink
  import vr_link_pkg::*;
#(
  parameter logic [3:0] READY_PATTERN = 4'b1111
) (
  input  logic  clk,
  input  logic  rst,
  input  word_t data,
  input  logic  valid,
  output logic  ready,
  output word_t data_out,
  output word_t xfer_count
);

  logic [3:0] mask_q, mask_d;
  logic       ready_q, ready_d;
  word_t      data_out_q, data_out_d;
  word_t      xfer_count_q, xfer_count_d;
  logic       xfer;

  // ready is a flop, so it cannot depend on valid combinationally.
  assign xfer = valid & ready_q;

  always_comb begin
    mask_d       = {mask_q[0], mask_q[3:1]};
    ready_d      = mask_q[0];
    data_out_d   = data_out_q;
    xfer_count_d = xfer_count_q;
    if (xfer) begin
      data_out_d   = data;
      xfer_count_d = xfer_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_q       <= READY_PATTERN;
      ready_q      <= 1'b0;
      data_out_q   <= '0;
      xfer_count_q <= '0;
    end else begin
      mask_q       <= mask_d;
      ready_q      <= ready_d;
      data_out_q   <= data_out_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign ready      = ready_q;
  assign data_out   = data_out_q;
  assign xfer_count = xfer_count_q;

endmodule

// File: rtl/vr_link.sv
// vr_link: self-contained valid/ready link. An incrementing-word source feeds a
// vr_sink with a programmable ready pattern; all bus signals are exported.
// Optional feature macro: VR_LINK_PROTOCOL_CHECK_EN enables the sticky protocol
// checker driving proto_err; otherwise proto_err is constant 0.
// Ports:
//   clk        - rising-edge clock
//   rst        - synchronous active-high reset
//   bus_data   - source data on the link
//   bus_valid  - source valid
//   bus_ready  - sink ready
//   data_out   - last word accepted by the sink
//   xfer_count - completed transfers, wraps at 2^16
//   proto_err  - sticky protocol-violation flag
module vr_link
  import vr_link_pkg::*;
#(
  parameter logic [15:0] START         = 16'h0000,
  parameter logic [15:0] STEP          = 16'h0001,
  parameter logic [3:0]  READY_PATTERN = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] bus_data,
  output logic        bus_valid,
  output logic        bus_ready,
  output logic [15:0] data_out,
  output logic [15:0] xfer_count,
  output logic        proto_err
);

  src_state_e state_q, state_d;
  word_t      data_q, data_d;
  logic       xfer;

  assign xfer = bus_valid & bus_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  // Next-state
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    unique case (state_q)
      IDLE: begin
        state_d = SEND;
        data_d  = START;
      end
      SEND: begin
        if (xfer) data_d = data_q + STEP;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus_valid = (state_q == SEND);
    bus_data  = data_q;
  end

  vr_sink #(
    .READY_PATTERN(READY_PATTERN)
  ) u_sink (
    .clk       (clk),
    .rst       (rst),
    .data      (bus_data),
    .valid     (bus_valid),
    .ready     (bus_ready),
    .data_out  (data_out),
    .xfer_count(xfer_count)
  );

`ifdef VR_LINK_PROTOCOL_CHECK_EN
  // Compares the bus against its value on the previous edge; a stalled word
  // (valid without ready) must be held, and valid may not drop before it moves.
  logic  last_valid_q, last_ready_q;
  word_t last_data_q;
  logic  err_q, err_d;
  logic  stalled;

  assign stalled = last_valid_q & ~last_ready_q;

  always_comb begin
    err_d = err_q;
    if (stalled && (!bus_valid || (bus_data != last_data_q))) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_valid_q <= 1'b0;
      last_ready_q <= 1'b0;
      last_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      last_valid_q <= bus_valid;
      last_ready_q <= bus_ready;
      last_data_q  <= bus_data;
      err_q        <= err_d;
    end
  end

  assign proto_err = err_q;
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_vr_link.sv
// tb_vr_link: directed bench for vr_link. Four instances run side by side:
//   a - defaults, b - READY_PATTERN 0101, c - START FFFE, d - READY_PATTERN 0000.
module tb_vr_link;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  logic [15:0] a_data, a_dout, a_cnt;
  logic        a_valid, a_ready, a_err;
  logic [15:0] b_data, b_dout, b_cnt;
  logic        b_valid, b_ready, b_err;
  logic [15:0] c_data, c_dout, c_cnt;
  logic        c_valid, c_ready, c_err;
  logic [15:0] d_data, d_dout, d_cnt;
  logic        d_valid, d_ready, d_err;

  vr_link dut_a (
    .clk(clk), .rst(rst), .bus_data(a_data), .bus_valid(a_valid), .bus_ready(a_ready),
    .data_out(a_dout), .xfer_count(a_cnt), .proto_err(a_err)
  );

  vr_link #(.READY_PATTERN(4'b0101)) dut_b (
    .clk(clk), .rst(rst), .bus_data(b_data), .bus_valid(b_valid), .bus_ready(b_ready),
    .data_out(b_dout), .xfer_count(b_cnt), .proto_err(b_err)
  );

  vr_link #(.START(16'hFFFE), .STEP(16'h0001)) dut_c (
    .clk(clk), .rst(rst), .bus_data(c_data), .bus_valid(c_valid), .bus_ready(c_ready),
    .data_out(c_dout), .xfer_count(c_cnt), .proto_err(c_err)
  );

  vr_link #(.START(16'h1234), .READY_PATTERN(4'b0000)) dut_d (
    .clk(clk), .rst(rst), .bus_data(d_data), .bus_valid(d_valid), .bus_ready(d_ready),
    .data_out(d_dout), .xfer_count(d_cnt), .proto_err(d_err)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock edge, then move to the sampling point.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_reset_a();
    check_eq("a_rst_valid", {31'd0, a_valid}, 32'd0);
    check_eq("a_rst_data", {16'd0, a_data}, 32'd0);
    check_eq("a_rst_ready", {31'd0, a_ready}, 32'd0);
    check_eq("a_rst_dout", {16'd0, a_dout}, 32'd0);
    check_eq("a_rst_cnt", {16'd0, a_cnt}, 32'd0);
    check_eq("a_rst_err", {31'd0, a_err}, 32'd0);
  endtask

  initial begin
    logic [15:0] exp_b_cnt;
    logic [15:0] exp_c;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_a();
    check_eq("b_rst_ready", {31'd0, b_ready}, 32'd0);
    check_eq("d_rst_data", {16'd0, d_data}, 32'd0);

    // Cycle 0
    rst = 1'b0;
    step();
    check_eq("a_c0_valid", {31'd0, a_valid}, 32'd1);
    check_eq("a_c0_data", {16'd0, a_data}, 32'd0);
    check_eq("a_c0_ready", {31'd0, a_ready}, 32'd1);
    check_eq("a_c0_cnt", {16'd0, a_cnt}, 32'd0);
    check_eq("b_c0_ready", {31'd0, b_ready}, 32'd1);
    check_eq("c_c0_data", {16'd0, c_data}, 32'h0000_FFFE);
    check_eq("d_c0_data", {16'd0, d_data}, 32'h0000_1234);
    check_eq("d_c0_ready", {31'd0, d_ready}, 32'd0);

    for (int k = 1; k <= 8; k++) begin
      step();
      // a: one word per cycle
      check_eq($sformatf("a_data_%0d", k), {16'd0, a_data}, k);
      check_eq($sformatf("a_dout_%0d", k), {16'd0, a_dout}, k - 1);
      check_eq($sformatf("a_cnt_%0d", k), {16'd0, a_cnt}, k);
      check_eq($sformatf("a_valid_%0d", k), {31'd0, a_valid}, 32'd1);
      // b: transfers on odd edges only
      exp_b_cnt = 16'((k + 1) / 2);
      check_eq($sformatf("b_ready_%0d", k), {31'd0, b_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
      check_eq($sformatf("b_data_%0d", k), {16'd0, b_data}, {16'd0, exp_b_cnt});
      check_eq($sformatf("b_cnt_%0d", k), {16'd0, b_cnt}, {16'd0, exp_b_cnt});
      check_eq($sformatf("b_dout_%0d", k), {16'd0, b_dout},
               (exp_b_cnt == 0) ? 32'd0 : {16'd0, exp_b_cnt - 16'd1});
      // c: wraps FFFE, FFFF, 0000, ...
      exp_c = 16'hFFFE + 16'(k);
      check_eq($sformatf("c_data_%0d", k), {16'd0, c_data}, {16'd0, exp_c});
      check_eq($sformatf("c_dout_%0d", k), {16'd0, c_dout}, {16'd0, exp_c - 16'd1});
      // d: never transfers
      check_eq($sformatf("d_data_%0d", k), {16'd0, d_data}, 32'h0000_1234);
      check_eq($sformatf("d_cnt_%0d", k), {16'd0, d_cnt}, 32'd0);
      check_eq($sformatf("d_dout_%0d", k), {16'd0, d_dout}, 32'd0);
      check_eq($sformatf("d_ready_%0d", k), {31'd0, d_ready}, 32'd0);
      check_eq($sformatf("errs_%0d", k), {28'd0, a_err, b_err, c_err, d_err}, 32'd0);
    end
    check_eq("b_cnt_after8", {16'd0, b_cnt}, 32'd4);
    check_eq("c_wrap_word", {16'd0, c_dout}, 32'h0000_0005);

    // Restart, five transfers, then reset mid-stream.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    repeat (5) step();
    check_eq("a_pre_cnt5", {16'd0, a_cnt}, 32'd5);
    check_eq("a_pre_data5", {16'd0, a_data}, 32'd5);
    rst = 1'b1;
    step();
    check_reset_a();
    rst = 1'b0;
    step();
    check_eq("a_restart_data", {16'd0, a_data}, 32'd0);
    check_eq("a_restart_cnt", {16'd0, a_cnt}, 32'd0);
    check_eq("a_restart_valid", {31'd0, a_valid}, 32'd1);
    step();
    check_eq("a_restart_data1", {16'd0, a_data}, 32'd1);
    check_eq("a_restart_dout1", {16'd0, a_dout}, 32'd0);
    check_eq("a_restart_cnt1", {16'd0, a_cnt}, 32'd1);

`ifdef VR_LINK_PROTOCOL_CHECK_EN
    // b stalls in the cycle after edge 1; change its data right after.
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    step();
    step();
    check_eq("b_err_clean", {31'd0, b_err}, 32'd0);
    force dut_b.bus_data = 16'hBEEF;
    step();
    release dut_b.bus_data;
    check_eq("b_err_set", {31'd0, b_err}, 32'd1);
    repeat (3) step();
    check_eq("b_err_sticky", {31'd0, b_err}, 32'd1);
    check_eq("a_err_clean", {31'd0, a_err}, 32'd0);
    rst = 1'b1;
    step();
    check_eq("b_err_cleared", {31'd0, b_err}, 32'd0);
    rst = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
